instruction_stepper: RTL and testbench

Sequencing controller for the 8-bit processor. It owns the six-step stepper ring and the instruction register, and drives the fetch controls for steps 1-3. It exposes the one-hot step vector that the micro-instruction decoder ANDs with opcode lines to form its step-4/5/6 controls. It also adds run/halt control, single-step mode, early instruction termination and a retired-instruction counter.

---
 rtl/instruction_stepper_pkg.sv | 19 +
 rtl/instruction_stepper_step_ring.sv | 22 ++
 rtl/instruction_stepper.sv | 99 +++++++++
 tb/tb_instruction_stepper.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_stepper_pkg.sv
// instruction_stepper_pkg: shared state encoding and step constants for the instruction stepper.
package instruction_stepper_pkg;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2
    } state_t;

    localparam int STEP1 = 0;
    localparam int STEP2 = 1;
    localparam int STEP3 = 2;
    localparam int STEP4 = 3;
    localparam int STEP5 = 4;
    localparam int STEP6 = 5;

    localparam logic [5:0] EARLY_DONE_MASK = 6'b111000;

endpackage

// File: rtl/instruction_stepper_step_ring.sv
// step_ring: one-hot step register; clear wins over start, start wins over advance.
module step_ring #(
    parameter int NUM_STEPS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 advance,
    output logic [NUM_STEPS-1:0] seq
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            seq <= '0;
        else
            seq <= clear   ? '0 :
                   start   ? NUM_STEPS'(1) :
                   advance ? {seq[NUM_STEPS-2:0], seq[NUM_STEPS-1]} : seq;
    end

endmodule

// File: rtl/instruction_stepper.sv
// instruction_stepper: run/halt/single-step sequencer owning the step ring, IR and retire counter.
module instruction_stepper
    import instruction_stepper_pkg::*;
#(
    parameter int NUM_STEPS = 6,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 step_mode,
    input  logic                 step_req,
    input  logic                 halt_req,
    input  logic                 instr_done,
    input  logic [7:0]           ir_in,
    output logic [NUM_STEPS-1:0] seq,
    output logic                 fetch1,
    output logic                 fetch2,
    output logic                 fetch3,
    output logic                 ir_load,
    output logic [7:0]           ir,
    output logic                 halted,
    output logic [CNT_W-1:0]     instr_count
);

    state_t state, state_d;
    logic   step_req_q, step_rise, retire;
    logic   clear, start, advance;

    step_ring #(.NUM_STEPS(NUM_STEPS)) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .start   (start),
        .advance (advance),
        .seq     (seq)
    );

    assign step_rise = step_req & ~step_req_q;
    // instr_done only counts once the decoder owns the step (4-6)
    assign retire    = seq[STEP6] | (instr_done & |(seq & EARLY_DONE_MASK));

    always_comb begin
        state_d = state;
        clear   = 1'b0;
        start   = 1'b0;
        advance = 1'b0;
        case (state)
            HALTED: begin
                if (!halt_req && !step_mode && run) begin
                    state_d = RUN;
                    start   = 1'b1;
                end else if (!halt_req && step_mode && step_rise) begin
                    state_d = STEP;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (retire && (halt_req || !run || step_mode)) begin
                    state_d = HALTED;
                    clear   = 1'b1;
                end else begin
                    start   = retire;
                    advance = !retire;
                end
            end
            STEP: begin
                state_d = retire ? HALTED : STEP;
                clear   = retire;
                advance = !retire;
            end
            default: begin
                state_d = HALTED;
                clear   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HALTED;
            step_req_q  <= 1'b0;
            ir          <= 8'h00;
            instr_count <= '0;
        end else begin
            state       <= state_d;
            step_req_q  <= step_req;
            ir          <= seq[STEP2] ? ir_in : ir;
            instr_count <= retire ? instr_count + 1'b1 : instr_count;
        end
    end

    assign fetch1  = seq[STEP1];
    assign fetch2  = seq[STEP2];
    assign fetch3  = seq[STEP3];
    assign ir_load = seq[STEP2];
    assign halted  = (state == HALTED);

endmodule

// File: tb/tb_instruction_stepper.sv
// tb_instruction_stepper: directed checks of run, early retire, halt, single-step, wrap and async reset.
module tb_instruction_stepper;

    logic       clk = 0;
    logic       rst_n, run, step_mode, step_req, halt_req, instr_done;
    logic [7:0] ir_in;
    logic [5:0] seq;
    logic       fetch1, fetch2, fetch3, ir_load, halted;
    logic [7:0] ir;
    logic [3:0] instr_count;
    int         checks = 0;
    int         errors = 0;

    instruction_stepper #(.NUM_STEPS(6), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step_mode(step_mode), .step_req(step_req),
        .halt_req(halt_req), .instr_done(instr_done), .ir_in(ir_in), .seq(seq),
        .fetch1(fetch1), .fetch2(fetch2), .fetch3(fetch3), .ir_load(ir_load), .ir(ir),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_seq(input string name, input logic [5:0] exp_seq, input logic exp_halted,
                           input logic [3:0] exp_cnt);
        checks++;
        if (seq !== exp_seq || halted !== exp_halted || instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL %s: seq=%b halted=%b count=%0d, expected seq=%b halted=%b count=%0d",
                     name, seq, halted, instr_count, exp_seq, exp_halted, exp_cnt);
        end
    endtask

    task automatic test_reset;
        rst_n = 0; run = 0; step_mode = 0; step_req = 0; halt_req = 0; instr_done = 0; ir_in = 8'h00;
        tick(2);
        rst_n = 1;
        tick();
        chk_seq("reset_state", 6'b000000, 1'b1, 4'd0);
        checks++;
        if (ir !== 8'h00 || fetch1 !== 1'b0 || ir_load !== 1'b0) begin
            errors++;
            $display("FAIL reset_ir: ir=%h fetch1=%b ir_load=%b, expected 00 0 0", ir, fetch1, ir_load);
        end
    endtask

    task automatic test_free_run;
        run = 1; ir_in = 8'hA5;
        tick();
        chk_seq("run_step1", 6'b000001, 1'b0, 4'd0);
        checks++;
        if ({fetch1, fetch2, fetch3, ir_load} !== 4'b1000) begin
            errors++;
            $display("FAIL run_fetch1: f1f2f3ld=%b, expected 1000", {fetch1, fetch2, fetch3, ir_load});
        end
        tick();
        checks++;
        if (seq !== 6'b000010 || {fetch1, fetch2, fetch3, ir_load} !== 4'b0101) begin
            errors++;
            $display("FAIL run_step2: seq=%b f1f2f3ld=%b, expected 000010 0101", seq,
                     {fetch1, fetch2, fetch3, ir_load});
        end
        tick();
        checks++;
        if (seq !== 6'b000100 || ir !== 8'hA5 || fetch3 !== 1'b1) begin
            errors++;
            $display("FAIL run_step3_ir: seq=%b ir=%h fetch3=%b, expected 000100 a5 1", seq, ir, fetch3);
        end
        ir_in = 8'h11;
        tick(3);
        chk_seq("run_step6", 6'b100000, 1'b0, 4'd0);
        checks++;
        if (ir !== 8'hA5) begin
            errors++;
            $display("FAIL ir_hold: ir=%h, expected a5", ir);
        end
        tick();
        chk_seq("run_retire", 6'b000001, 1'b0, 4'd1);
    endtask

    task automatic test_early_retire;
        tick(2);
        instr_done = 1;
        tick();
        chk_seq("done_at_step3_ignored", 6'b001000, 1'b0, 4'd1);
        instr_done = 0;
        tick();
        chk_seq("after_ignored_done", 6'b010000, 1'b0, 4'd1);
        tick(2);
        chk_seq("full_retire_2", 6'b000001, 1'b0, 4'd2);
        tick(3);
        instr_done = 1;
        tick();
        chk_seq("early_retire_step4", 6'b000001, 1'b0, 4'd3);
        instr_done = 0;
        tick(4);
        instr_done = 1;
        tick();
        chk_seq("early_retire_step5", 6'b000001, 1'b0, 4'd4);
        instr_done = 0;
    endtask

    task automatic test_halt;
        tick(2);
        halt_req = 1;
        tick(3);
        chk_seq("halt_completes_instr", 6'b100000, 1'b0, 4'd4);
        tick();
        chk_seq("halt_reached", 6'b000000, 1'b1, 4'd5);
        tick(3);
        chk_seq("halt_blocks_run", 6'b000000, 1'b1, 4'd5);
        halt_req = 0; run = 0;
        tick();
        chk_seq("idle_halted", 6'b000000, 1'b1, 4'd5);
    endtask

    task automatic test_single_step;
        step_mode = 1; run = 1;
        tick();
        chk_seq("step_mode_ignores_run", 6'b000000, 1'b1, 4'd5);
        run = 0; step_req = 1; ir_in = 8'h3C;
        tick();
        chk_seq("step_start", 6'b000001, 1'b0, 4'd5);
        step_req = 0;
        tick();
        step_req = 1;
        tick();
        chk_seq("step_second_pulse_step3", 6'b000100, 1'b0, 4'd5);
        checks++;
        if (ir !== 8'h3C) begin
            errors++;
            $display("FAIL step_ir: ir=%h, expected 3c", ir);
        end
        step_req = 0;
        tick(3);
        chk_seq("step_step6", 6'b100000, 1'b0, 4'd5);
        tick();
        chk_seq("step_done_halted", 6'b000000, 1'b1, 4'd6);
        tick(3);
        chk_seq("step_pulse_not_queued", 6'b000000, 1'b1, 4'd6);
    endtask

    task automatic test_counter_wrap;
        step_mode = 0; run = 1; instr_done = 1;
        tick();
        chk_seq("wrap_start", 6'b000001, 1'b0, 4'd6);
        tick(36);
        chk_seq("wrap_all_ones", 6'b000001, 1'b0, 4'd15);
        tick(4);
        chk_seq("wrap_to_zero", 6'b000001, 1'b0, 4'd0);
        instr_done = 0;
    endtask

    task automatic test_async_reset;
        tick(2);
        rst_n = 0;
        #1;
        chk_seq("async_reset", 6'b000000, 1'b1, 4'd0);
        checks++;
        if (ir !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_ir: ir=%h, expected 00", ir);
        end
        run = 0;
        tick();
        rst_n = 1;
        tick();
        chk_seq("post_reset_idle", 6'b000000, 1'b1, 4'd0);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_early_retire();
        test_halt();
        test_single_step();
        test_counter_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
